// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encodings, NZCV flag bit positions and the
// writeback entry record carried through the result stage.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_RD_W   = 5;
  localparam int ALU_SEL_W  = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_OP_ADD = 3'b000,
    ALU_OP_SUB = 3'b001,
    ALU_OP_AND = 3'b010,
    ALU_OP_OR  = 3'b011,
    ALU_OP_XOR = 3'b100,
    ALU_OP_SLL = 3'b101,
    ALU_OP_SRL = 3'b110,
    ALU_OP_SLT = 3'b111
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_RD_W-1:0]   rd;
    logic                  we;
    logic [3:0]            flags;
  } wb_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation for one ALU result. Carry and overflow are only
// meaningful for the adder ops; every other op reports C=V=0.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
) (
  input  logic signed [DATA_W-1:0] result,
  input  logic        [SEL_W-1:0]  sel,
  input  logic                     carry,
  input  logic                     ovf,
  output logic        [3:0]        flags
);

  logic is_addsub;

  assign is_addsub = (sel == SEL_W'(ALU_OP_ADD)) || (sel == SEL_W'(ALU_OP_SUB));

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = (result < 0);
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = is_addsub && carry;
    flags[FLAG_V] = is_addsub && ovf;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: main register plus one skid entry, valid/ready on both
// sides, in_ready derived from state only. Optional ALU_RESULT_FWD_EN adds fwd0/fwd1 views.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int RD_W   = ALU_RD_W,
  parameter int SEL_W  = ALU_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
`ifdef ALU_RESULT_FWD_EN
  output logic              fwd0_valid,
  output logic [RD_W-1:0]   fwd0_rd,
  output logic [DATA_W-1:0] fwd0_data,
  output logic              fwd1_valid,
  output logic [RD_W-1:0]   fwd1_rd,
  output logic [DATA_W-1:0] fwd1_data,
`endif
  output logic [3:0]        out_flags
);

  logic [3:0] cap_flags;
  wb_entry_t  cap_p0;
  wb_entry_t  main_p1;
  wb_entry_t  skid_p1;
  logic       vld_p1;
  logic       skid_vld_p1;
  logic       fire_in;
  logic       main_load;

  // ---- p0: capture the incoming result and derive its flags ----
  alu_flag_gen #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_flag_gen (
    .result (in_result),
    .sel    (in_sel),
    .carry  (in_carry),
    .ovf    (in_ovf),
    .flags  (cap_flags)
  );

  always_comb begin
    cap_p0        = '0;
    cap_p0.result = in_result;
    cap_p0.rd     = in_rd;
    cap_p0.we     = in_we && (in_rd != '0);
    cap_p0.flags  = cap_flags;
  end

  assign in_ready  = !skid_vld_p1 && !rst;
  assign fire_in   = in_valid && in_ready;
  assign main_load = !vld_p1 || out_ready;

  // ---- p1: main entry and skid entry ----
  // A full skid forces in_ready low, so the skid never receives while it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (main_load) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (fire_in) begin
        main_p1 <= cap_p0;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (fire_in) begin
      skid_p1     <= cap_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = main_p1.result;
  assign out_rd     = main_p1.rd;
  assign out_we     = main_p1.we;
  assign out_flags  = main_p1.flags;

`ifdef ALU_RESULT_FWD_EN
  assign fwd0_valid = vld_p1 && main_p1.we;
  assign fwd0_rd    = main_p1.rd;
  assign fwd0_data  = main_p1.result;
  assign fwd1_valid = skid_vld_p1 && skid_p1.we;
  assign fwd1_rd    = skid_p1.rd;
  assign fwd1_data  = skid_p1.result;
`endif

endmodule
